// File: rtl/uart_pkg.sv
// Shared types and the parity helper for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int unsigned MAX_DATA_W = 9;

   // Callers zero-extend narrower words; the extra zeros do not change the XOR.
   function automatic logic par_calc(input logic [MAX_DATA_W-1:0] data, input parity_e mode);
      logic w_even;
      w_even = ^data;
      return (mode == PAR_ODD) ? ~w_even : w_even;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: pulses bit_end_o in the last cycle of every CLKS_PER_BIT-cycle period.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic run_i,
   output logic bit_end_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last    = (r_cnt == LAST_CNT);
   assign bit_end_o = run_i && w_last;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_cnt <= '0;
      end else if (!run_i || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one word over valid/ready and emits a framed character
// (start, data, optional parity, stop) on an idle-high registered line.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter parity_e     PARITY       = PAR_NONE,
   parameter int unsigned STOP_BITS    = 1,
   parameter bit          LSB_FIRST    = 1'b1
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              serial_out_o,
   output logic              busy_o,
   output logic              done_o
);

   if (DATA_W < 5 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
      $error("uart_tx_serializer: DATA_W must be in 5..9");
   end
   if (CLKS_PER_BIT < 1) begin : g_bad_clks
      $error("uart_tx_serializer: CLKS_PER_BIT must be >= 1");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
      $error("uart_tx_serializer: PARITY must be PAR_NONE, PAR_EVEN or PAR_ODD");
   end

   localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   tx_state_e             r_state, w_state_nxt;
   logic [DATA_W-1:0]     r_shift, w_shift_nxt;
   logic                  r_par, w_par_nxt;
   logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
   logic                  r_tx, w_tx_nxt;
   logic                  r_done, w_done_nxt;
   logic [DATA_W-1:0]     w_data_ord;
   logic [MAX_DATA_W-1:0] w_data_ext;
   logic                  w_bit_end;

   assign w_data_ext = MAX_DATA_W'(data_i);

   // Pre-reversing for MSB-first keeps the shifter a plain right shift in both modes.
   always_comb begin
      w_data_ord = data_i;
      if (!LSB_FIRST) begin
         for (int i = 0; i < int'(DATA_W); i++) begin
            w_data_ord[i] = data_i[int'(DATA_W) - 1 - i];
         end
      end
   end

   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .run_i     (r_state != IDLE),
      .bit_end_o (w_bit_end)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_par_nxt     = r_par;
      w_bit_cnt_nxt = r_bit_cnt;
      w_tx_nxt      = r_tx;
      w_done_nxt    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_tx_nxt = 1'b1;
            if (valid_i) begin
               w_state_nxt   = START;
               w_shift_nxt   = w_data_ord;
               w_par_nxt     = (PARITY != PAR_NONE) ? par_calc(w_data_ext, PARITY) : 1'b0;
               w_bit_cnt_nxt = '0;
               w_tx_nxt      = 1'b0;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt   = DATA;
               w_bit_cnt_nxt = '0;
               w_tx_nxt      = r_shift[0];
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_bit_cnt == LAST_DATA) begin
                  w_bit_cnt_nxt = '0;
                  if (PARITY != PAR_NONE) begin
                     w_state_nxt = uart_pkg::PARITY;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_shift_nxt   = r_shift >> 1;
                  w_tx_nxt      = r_shift[1];
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (w_bit_end) begin
               w_state_nxt   = STOP;
               w_bit_cnt_nxt = '0;
               w_tx_nxt      = 1'b1;
            end
         end
         STOP: begin
            w_tx_nxt = 1'b1;
            if (w_bit_end) begin
               if (r_bit_cnt == LAST_STOP) begin
                  w_state_nxt   = IDLE;
                  w_bit_cnt_nxt = '0;
                  w_done_nxt    = 1'b1;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            w_tx_nxt      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_par     <= w_par_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_tx      <= w_tx_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign ready_o      = (r_state == IDLE);
   assign busy_o       = (r_state != IDLE);
   assign serial_out_o = r_tx;
   assign done_o       = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: five parameter sets, expected line patterns hand-written.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   logic       clk;
   logic       reset_n;
   logic [4:0] valid;
   logic [8:0] data [5];
   wire  [4:0] ready;
   wire  [4:0] serial;
   wire  [4:0] busy;
   wire  [4:0] done;

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(PAR_EVEN), .STOP_BITS(1),
                        .LSB_FIRST(1'b1)) u_even (
      .clk_i(clk), .reset_ni(reset_n), .data_i(data[0][7:0]), .valid_i(valid[0]),
      .ready_o(ready[0]), .serial_out_o(serial[0]), .busy_o(busy[0]), .done_o(done[0]));

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(PAR_ODD), .STOP_BITS(1),
                        .LSB_FIRST(1'b1)) u_odd (
      .clk_i(clk), .reset_ni(reset_n), .data_i(data[1][7:0]), .valid_i(valid[1]),
      .ready_o(ready[1]), .serial_out_o(serial[1]), .busy_o(busy[1]), .done_o(done[1]));

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(PAR_NONE), .STOP_BITS(2),
                        .LSB_FIRST(1'b1)) u_stop2 (
      .clk_i(clk), .reset_ni(reset_n), .data_i(data[2][7:0]), .valid_i(valid[2]),
      .ready_o(ready[2]), .serial_out_o(serial[2]), .busy_o(busy[2]), .done_o(done[2]));

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY(PAR_NONE), .STOP_BITS(1),
                        .LSB_FIRST(1'b0)) u_msb (
      .clk_i(clk), .reset_ni(reset_n), .data_i(data[3][7:0]), .valid_i(valid[3]),
      .ready_o(ready[3]), .serial_out_o(serial[3]), .busy_o(busy[3]), .done_o(done[3]));

   uart_tx_serializer #(.DATA_W(5), .CLKS_PER_BIT(3), .PARITY(PAR_EVEN), .STOP_BITS(1),
                        .LSB_FIRST(1'b1)) u_w5 (
      .clk_i(clk), .reset_ni(reset_n), .data_i(data[4][4:0]), .valid_i(valid[4]),
      .ready_o(ready[4]), .serial_out_o(serial[4]), .busy_o(busy[4]), .done_o(done[4]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge. seq lists line levels bit by bit, start bit first.
   // Returns just after the falling edge inside the done_o cycle.
   task automatic frame_chk(input int idx, input logic [8:0] word, input int cpb,
                            input string seq, input bit keep_valid,
                            input logic [8:0] next_word, input string tag);
      int len;
      len        = seq.len() * cpb;
      data[idx]  = word;
      valid[idx] = 1'b1;
      @(posedge clk);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         check($sformatf("%s line c%0d", tag, k), 32'(serial[idx]),
               (seq[k / cpb] == "1") ? 32'd1 : 32'd0);
         check($sformatf("%s ready c%0d", tag, k), 32'(ready[idx]), 32'd0);
         check($sformatf("%s done c%0d", tag, k), 32'(done[idx]), 32'd0);
         if (k == 0) begin
            if (!keep_valid) valid[idx] = 1'b0;
            data[idx] = ~word;
         end
         if (k == len - 1 && keep_valid) data[idx] = next_word;
      end
      @(negedge clk);
      check($sformatf("%s done pulse", tag), 32'(done[idx]), 32'd1);
      check($sformatf("%s ready at done", tag), 32'(ready[idx]), 32'd1);
      check($sformatf("%s line at done", tag), 32'(serial[idx]), 32'd1);
   endtask

   initial begin
      reset_n = 1'b0;
      valid   = '0;
      for (int i = 0; i < 5; i++) data[i] = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("reset line u%0d", i), 32'(serial[i]), 32'd1);
         check($sformatf("reset ready u%0d", i), 32'(ready[i]), 32'd1);
         check($sformatf("reset busy u%0d", i), 32'(busy[i]), 32'd0);
         check($sformatf("reset done u%0d", i), 32'(done[i]), 32'd0);
      end
      reset_n = 1'b1;
      @(negedge clk);

      frame_chk(0, 9'h0A5, 4, "01010010101", 1'b0, 9'h000, "even_a5");
      frame_chk(1, 9'h0A5, 4, "01010010111", 1'b0, 9'h000, "odd_a5");
      frame_chk(2, 9'h0A5, 4, "01010010111", 1'b0, 9'h000, "none_stop2");
      frame_chk(3, 9'h001, 1, "0000000011", 1'b0, 9'h000, "msb_first");
      frame_chk(4, 9'h01F, 3, "01111111", 1'b0, 9'h000, "w5_even");

      // valid held high across two words; second accept lands in the done_o cycle
      frame_chk(0, 9'h03C, 4, "00011110001", 1'b1, 9'h0C3, "b2b_3c");
      frame_chk(0, 9'h0C3, 4, "01100001101", 1'b0, 9'h000, "b2b_c3");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("no dup line c%0d", k), 32'(serial[0]), 32'd1);
         check($sformatf("no dup ready c%0d", k), 32'(ready[0]), 32'd1);
      end

      // asynchronous reset in the middle of the data bits of 0xFF
      data[0]  = 9'h0FF;
      valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (6) @(negedge clk);
      check("mid busy", 32'(busy[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("async line", 32'(serial[0]), 32'd1);
      check("async ready", 32'(ready[0]), 32'd1);
      check("async busy", 32'(busy[0]), 32'd0);
      check("async done", 32'(done[0]), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("post rst done c%0d", k), 32'(done[0]), 32'd0);
         check($sformatf("post rst ready c%0d", k), 32'(ready[0]), 32'd1);
      end
      frame_chk(0, 9'h055, 4, "01010101001", 1'b0, 9'h000, "after_rst_55");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parametrised UART transmit serializer: the next generation of the byte shift register in the UART path. It adds configurable data width, parity, stop bits, bit order, an internal bit-period counter and a valid/ready load handshake. It accepts one parallel word and emits a complete framed serial character on an idle-high line. It sits between the UART TX holding logic (or FIFO) and the TX pad.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clk_i cycles per serial bit; must be >= 1.
PARITY, PAR_NONE, parity mode from uart_pkg: PAR_NONE, PAR_EVEN or PAR_ODD.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
LSB_FIRST, 1, 1 = data LSB sent first; 0 = data MSB sent first.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
reset_ni  input  1  asynchronous, active-low reset.
data_i  input  DATA_W  word to transmit; sampled only on accept.
valid_i  input  1  data_i is valid.
ready_o  output  1  block can accept a word; high only in IDLE.
serial_out_o  output  1  registered TX line; idles high.
busy_o  output  1  frame in progress (state != IDLE).
done_o  output  1  one-cycle pulse when a frame's final stop bit completes.

Behaviour:
- Reset (reset_ni low, asynchronous): state=IDLE, serial_out_o=1, ready_o=1, busy_o=0, done_o=0, bit and cycle counters=0, shift register=0.
- Reset mid-frame: the line returns high immediately and the frame is abandoned. No done_o pulse is produced.
- Accept: an accept occurs on a rising edge where state==IDLE and valid_i==1. On that edge:
  - data_i is captured into the shift register, pre-reversed if LSB_FIRST==0.
  - If PARITY!=PAR_NONE, the parity bit is computed and captured. Even parity = XOR of data_i; odd parity = its inverse.
  - state goes to START.
  - serial_out_o goes to 0 on the same edge, so the start bit is visible in the next cycle.
- valid_i while busy is ignored. Upstream must hold valid_i until ready_o is high. data_i changes after accept do not affect the frame in progress.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - START: one bit period.
  - DATA: DATA_W bit periods. The shift register shifts right by 1 at each period end, and serial_out_o takes the new bit 0.
  - PARITY: one bit period; present only when PARITY!=PAR_NONE.
  - STOP: STOP_BITS bit periods, line=1.
- Bit period: a cycle counter of width $clog2(CLKS_PER_BIT)+1 counts 0..CLKS_PER_BIT-1. Every line level is held exactly CLKS_PER_BIT cycles. With CLKS_PER_BIT==1, the line changes every cycle.
- Frame length: (1 + DATA_W + (PARITY!=PAR_NONE) + STOP_BITS) * CLKS_PER_BIT cycles, from the first low cycle to the end of the last stop cycle.
- End of frame: at the edge ending the last stop period, state goes to IDLE and done_o=1 for exactly that following cycle. ready_o is also 1 in that cycle.
- Back-to-back: if valid_i is high in the done_o cycle, the next start bit begins the cycle after. The minimum line-high gap between frames is therefore STOP_BITS*CLKS_PER_BIT + 1 cycles.
- busy_o = !ready_o. Both are decoded from the state register (registered state, no combinational path from inputs).
- Illegal parameter values cause a failure at elaboration via static assertion.

Decomposition:
- uart_pkg holds:
  - parity_e (PAR_NONE, PAR_EVEN, PAR_ODD);
  - tx_state_e (IDLE, START, DATA, PARITY, STOP);
  - the shared function par_calc(data, mode).
- One sub-module, uart_bit_timer: parametrised by CLKS_PER_BIT. Inputs are clk_i, reset_ni and a run enable; output is bit_end_o, a pulse in the last cycle of each period. The counter clears while run is low.
- The shift/FSM logic stays in uart_tx_serializer.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, PAR_EVEN, STOP_BITS=1, LSB_FIRST=1; send 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles; total 44 cycles; one done_o pulse; ready_o low for exactly 44 cycles after the accept edge.
- Same configuration with PAR_ODD, send 0xA5 -> parity bit 1; with PAR_NONE, STOP_BITS=2 -> frame is 0,data,1,1 = 44 cycles.
- LSB_FIRST=0, PAR_NONE, CLKS_PER_BIT=1; send 0x01 -> data bits 0,0,0,0,0,0,0,1 on consecutive cycles; total frame 10 cycles.
- valid_i held high with words 0x3C then 0xC3 -> the second accept happens in the done_o cycle; start bit of 0xC3 is the following cycle; no word lost or duplicated; data_i toggling mid-frame has no effect.
- reset_ni asserted asynchronously mid-DATA of 0xFF -> serial_out_o=1 before the next clock edge; ready_o=1, no done_o pulse; after release, a new 0x55 frame is transmitted correctly.
- DATA_W=5, CLKS_PER_BIT=3, PAR_EVEN; send 5'h1F -> parity 1; frame length (1+5+1+1)*3 = 24 cycles.
